// File: rtl/feature_writeback_pkg.sv
// Types and shared constants for the feature writeback path.
`ifndef FWB_PARA_SV
`include "Para.sv"
`endif

package feature_writeback_pkg;

  localparam int WIDTH_DATA  = `WIDTH_DATA;
  localparam int PICTURE_NUM = `PICTURE_NUM;

  typedef enum logic [1:0] {
    ST_IDLE  = `FWB_ST_IDLE,
    ST_RUN   = `FWB_ST_RUN,
    ST_DRAIN = `FWB_ST_DRAIN,
    ST_DONE  = `FWB_ST_DONE
  } wb_state_e;

endpackage

// File: rtl/Para.sv
// Shared datapath widths and writeback FSM state encodings.
// Guarded so it can be both compiled directly and included by the package.
`ifndef FWB_PARA_SV
`define FWB_PARA_SV

`define WIDTH_DATA   8
`define PICTURE_NUM  1

`define FWB_ST_IDLE  2'd0
`define FWB_ST_RUN   2'd1
`define FWB_ST_DRAIN 2'd2
`define FWB_ST_DONE  2'd3

`endif

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and a registered head word.
module wb_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
    // The head bypasses the array when the incoming word becomes the new head.
    if (do_push && (empty_q || (do_pop && count_q == COUNT_ONE))) begin
      head_d = wdata_i;
    end else if (do_pop && count_q != COUNT_ONE) begin
      head_d = mem_q[rd_ptr_d];
    end
    full_d  = (count_d == COUNT_FULL);
    empty_d = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      head_q   <= head_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = head_q;

endmodule

// File: rtl/feature_writeback.sv
// Collects conv result beats for one layer, tags the final beat and streams them
// out through a small FIFO; Done holds until the controller acknowledges.
module feature_writeback
  import feature_writeback_pkg::*;
#(
  parameter int CHANNEL_OUT_NUM    = 8,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM  = 10,
  parameter int FIFO_DEPTH         = 16,
  parameter int WIDTH_BEAT         = 34
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             Start,
  input  logic                                             Next_Reg,
  input  logic [WIDTH_DATA*PICTURE_NUM*CHANNEL_OUT_NUM-1:0] S_Data,
  input  logic                                             S_Valid,
  output logic                                             S_Ready,
  input  logic [WIDTH_FEATURE_SIZE-1:0]                    Row_Num_Out_REG,
  input  logic [WIDTH_CHANNEL_NUM-1:0]                     Channel_Out_Num_REG,
  output logic [WIDTH_DATA*PICTURE_NUM*CHANNEL_OUT_NUM-1:0] M_Data,
  output logic                                             M_Valid,
  input  logic                                             M_Ready,
  output logic                                             M_Last,
  output logic                                             Done
);

  localparam int WIDTH_BUS = WIDTH_DATA * PICTURE_NUM * CHANNEL_OUT_NUM;

  wb_state_e                     state_q, state_d;
  logic [WIDTH_FEATURE_SIZE-1:0] w_q, w_d, col_q, col_d, row_q, row_d;
  logic [WIDTH_CHANNEL_NUM-1:0]  g_q, g_d, grp_q, grp_d;
  logic [WIDTH_BEAT-1:0]         total_q, total_d, beat_q, beat_d;

  logic                 push, pop, last_beat;
  logic                 fifo_full, fifo_empty, head_last;
  logic [WIDTH_BUS-1:0] head_data;

  assign S_Ready   = (state_q == ST_RUN) && !fifo_full;
  assign push      = S_Valid && S_Ready;
  assign M_Valid   = !fifo_empty;
  assign pop       = M_Valid && M_Ready;
  assign M_Data    = head_data;
  assign M_Last    = head_last;
  assign Done      = (state_q == ST_DONE);
  assign last_beat = (beat_q == total_q - WIDTH_BEAT'(1));

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    g_d     = g_q;
    total_d = total_q;
    beat_d  = beat_q;
    grp_d   = grp_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (Start && Row_Num_Out_REG != '0 && Channel_Out_Num_REG != '0) begin
          w_d     = Row_Num_Out_REG;
          g_d     = Channel_Out_Num_REG;
          total_d = WIDTH_BEAT'(Row_Num_Out_REG) * WIDTH_BEAT'(Row_Num_Out_REG)
                  * WIDTH_BEAT'(Channel_Out_Num_REG);
          beat_d  = '0;
          grp_d   = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (push) begin
          beat_d = beat_q + WIDTH_BEAT'(1);
          // Channel group is the fastest-moving index, then column, then row.
          if (grp_q == g_q - WIDTH_CHANNEL_NUM'(1)) begin
            grp_d = '0;
            if (col_q == w_q - WIDTH_FEATURE_SIZE'(1)) begin
              col_d = '0;
              row_d = row_q + WIDTH_FEATURE_SIZE'(1);
            end else begin
              col_d = col_q + WIDTH_FEATURE_SIZE'(1);
            end
          end else begin
            grp_d = grp_q + WIDTH_CHANNEL_NUM'(1);
          end
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (Next_Reg) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      g_q     <= '0;
      total_q <= '0;
      beat_q  <= '0;
      grp_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      g_q     <= g_d;
      total_q <= total_d;
      beat_q  <= beat_d;
      grp_q   <= grp_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  wb_sync_fifo #(
    .WIDTH (WIDTH_BUS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({last_beat, S_Data}),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  ({head_last, head_data})
  );

endmodule

// File: tb/tb_feature_writeback.sv
// Directed self-checking bench for feature_writeback: ordering, framing,
// backpressure, ignored Start/Next_Reg cases and mid-layer reset.
module tb_feature_writeback;
  import feature_writeback_pkg::*;

  localparam int BW = WIDTH_DATA * PICTURE_NUM * 8;

  logic          clk;
  logic          rst;
  logic          Start, Next_Reg;
  logic [BW-1:0] S_Data;
  logic          S_Valid, S_Ready;
  logic [11:0]   Row_Num_Out_REG;
  logic [9:0]    Channel_Out_Num_REG;
  logic [BW-1:0] M_Data;
  logic          M_Valid, M_Ready, M_Last, Done;

  int vectors    = 0;
  int miscompares = 0;
  int pushed     = 0;
  int popped     = 0;
  int base       = 0;

  feature_writeback dut (
    .clk                 (clk),
    .rst                 (rst),
    .Start               (Start),
    .Next_Reg            (Next_Reg),
    .S_Data              (S_Data),
    .S_Valid             (S_Valid),
    .S_Ready             (S_Ready),
    .Row_Num_Out_REG     (Row_Num_Out_REG),
    .Channel_Out_Num_REG (Channel_Out_Num_REG),
    .M_Data              (M_Data),
    .M_Valid             (M_Valid),
    .M_Ready             (M_Ready),
    .M_Last              (M_Last),
    .Done                (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  function automatic logic [BW-1:0] beat(input int i);
    return BW'({32'(base), 32'(i + 1)});
  endfunction

  task automatic start_layer(input int w, input int g);
    Row_Num_Out_REG     = 12'(w);
    Channel_Out_Num_REG = 10'(g);
    Start = 1'b1;
    step();
    Start  = 1'b0;
    pushed = 0;
    popped = 0;
  endtask

  task automatic ack_done();
    Next_Reg = 1'b1;
    step();
    Next_Reg = 1'b0;
    check("ack_done_low", Done, 1'b0);
  endtask

  // mode 0: M_Ready held high; mode 1: M_Ready alternates 1,0.
  task automatic stream(input int n, input int mode, input int limit);
    int  cyc;
    logic do_push, do_pop;
    cyc = 0;
    while (!Done && cyc < limit) begin
      M_Ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      S_Valid = (pushed < n);
      S_Data  = beat(pushed);
      if (M_Valid) begin
        check("head_data", M_Data, beat(popped));
        check("head_last", M_Last, (popped == n - 1));
      end
      do_push = S_Valid && S_Ready;
      do_pop  = M_Valid && M_Ready;
      step();
      if (do_push) pushed++;
      if (do_pop)  popped++;
      cyc++;
    end
    S_Valid = 1'b0;
    check("stream_done", Done, 1'b1);
    check("stream_popped", 64'(popped), 64'(n));
    check("stream_pushed", 64'(pushed), 64'(n));
    check("stream_empty", M_Valid, 1'b0);
  endtask

  initial begin
    logic do_push;
    rst = 1'b1; Start = 1'b0; Next_Reg = 1'b0;
    S_Data = '0; S_Valid = 1'b0; M_Ready = 1'b0;
    Row_Num_Out_REG = '0; Channel_Out_Num_REG = '0;
    step();
    step();
    check("rst_s_ready", S_Ready, 1'b0);
    check("rst_m_valid", M_Valid, 1'b0);
    check("rst_m_last",  M_Last,  1'b0);
    check("rst_done",    Done,    1'b0);
    check("rst_m_data",  M_Data,  64'h0);
    rst = 1'b0;
    step();

    // W=2, G=1: four beats, each visible one cycle after its push.
    M_Ready = 1'b1;
    start_layer(2, 1);
    check("t1_s_ready", S_Ready, 1'b1);
    S_Valid = 1'b1; S_Data = 64'h01; step();
    check("t1_d1", M_Data, 64'h01); check("t1_v1", M_Valid, 1'b1); check("t1_l1", M_Last, 1'b0);
    S_Data = 64'h02; step();
    check("t1_d2", M_Data, 64'h02); check("t1_l2", M_Last, 1'b0);
    S_Data = 64'h03; step();
    check("t1_d3", M_Data, 64'h03); check("t1_l3", M_Last, 1'b0);
    S_Data = 64'h04; step();
    S_Valid = 1'b0;
    check("t1_d4", M_Data, 64'h04); check("t1_l4", M_Last, 1'b1);
    check("t1_drain_s_ready", S_Ready, 1'b0);
    check("t1_done_early", Done, 1'b0);
    step();
    check("t1_done", Done, 1'b1);
    check("t1_empty", M_Valid, 1'b0);
    ack_done();
    step();
    check("t1_idle_s_ready", S_Ready, 1'b0);

    // W=3, G=2 with M_Ready low: FIFO fills at 16, then drains all 18.
    base = 32'h100;
    M_Ready = 1'b0;
    start_layer(3, 2);
    for (int c = 0; c < 20; c++) begin
      S_Valid = 1'b1;
      S_Data  = beat(pushed);
      do_push = S_Ready;
      step();
      if (do_push) pushed++;
    end
    check("t2_fill_count", 64'(pushed), 64'd16);
    check("t2_full_s_ready", S_Ready, 1'b0);
    check("t2_head", M_Data, beat(0));
    check("t2_head_last", M_Last, 1'b0);
    stream(18, 0, 100);
    ack_done();

    // W=2, G=2 with M_Ready toggling: stalled head must hold.
    base = 32'h200;
    start_layer(2, 2);
    stream(8, 1, 100);
    ack_done();

    // Zero width: Start ignored.
    start_layer(0, 1);
    step();
    check("t4_zero_s_ready", S_Ready, 1'b0);
    check("t4_zero_done", Done, 1'b0);
    check("t4_zero_m_valid", M_Valid, 1'b0);

    // Second Start during RUN with a different width is ignored.
    base = 32'h300;
    start_layer(2, 2);
    Row_Num_Out_REG = 12'd3;
    Start = 1'b1;
    step();
    Start = 1'b0;
    stream(8, 0, 100);
    ack_done();

    // Reset after three of eight beats flushes everything.
    base = 32'h400;
    M_Ready = 1'b0;
    start_layer(2, 2);
    for (int c = 0; c < 3; c++) begin
      S_Valid = 1'b1;
      S_Data  = beat(c);
      step();
    end
    S_Valid = 1'b0;
    check("t5_pre_rst_valid", M_Valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_m_valid", M_Valid, 1'b0);
    check("t5_rst_s_ready", S_Ready, 1'b0);
    check("t5_rst_m_data", M_Data, 64'h0);
    check("t5_rst_done", Done, 1'b0);
    base = 32'h500;
    start_layer(2, 2);
    stream(8, 0, 100);

    // Start and Next_Reg together in DONE: Next_Reg wins.
    Row_Num_Out_REG = 12'd2;
    Channel_Out_Num_REG = 10'd1;
    Start = 1'b1;
    Next_Reg = 1'b1;
    step();
    Start = 1'b0;
    Next_Reg = 1'b0;
    check("t6_done_low", Done, 1'b0);
    step();
    check("t6_no_restart", S_Ready, 1'b0);
    check("t6_still_idle", Done, 1'b0);
    base = 32'h600;
    start_layer(2, 1);
    stream(4, 0, 50);
    ack_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
